// File: rtl/temp_codes.sv
// Display codes and FSM encoding shared by the BCD converter and the 7-segment decoder.
// The 0xA-0xF nibble values must stay in step with the decoder's error/blank glyphs.
package temp_codes;

    localparam logic [7:0] OVER_CODE  = 8'hAA;
    localparam logic [7:0] FAULT_CODE = 8'hEE;
    localparam logic [7:0] BLANK_CODE = 8'hFF;

    // Three BCD digits cover any 8-bit input, including the ignored hundreds digit.
    localparam int SCR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/temp_bcd_converter.sv
// Sequential binary-to-BCD converter for the temperature display path.
// One sample takes a fixed 9 edges from capture to the decimalTemp update.
module temp_bcd_converter #(
    parameter int         IN_W       = 8,
    parameter int         MAX_DISP   = 99,
    parameter logic [7:0] OVER_CODE  = temp_codes::OVER_CODE,
    parameter logic [7:0] FAULT_CODE = temp_codes::FAULT_CODE,
    parameter logic [7:0] BLANK_CODE = temp_codes::BLANK_CODE
) (
    input  logic            sysCLK,
    input  logic            reset,
    input  logic            tempValid,
    input  logic [IN_W-1:0] tempBin,
    input  logic            sensorFault,
    output logic [7:0]      decimalTemp,
    output logic            display,
    output logic            busy,
    output logic            updated
);

    import temp_codes::*;

    localparam int              CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);
    localparam logic [IN_W-1:0]  MAX_V = IN_W'(MAX_DISP);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [IN_W-1:0]   op;
    logic              fault_op;
    logic              over_op;
    logic [SCR_W-1:0]  scratch;
    logic [SCR_W-1:0]  scratch_adj;
    logic              pend_vld;
    logic [IN_W-1:0]   pend_bin;
    logic              pend_fault;
    logic              load;
    logic [IN_W-1:0]   load_bin;
    logic              load_fault;

    // Fault outranks range; the overflow flag comes from the binary, so the hundreds digit never shows.
    function automatic logic [7:0] sel_code(input logic fault, input logic over,
                                            input logic [7:0] digits);
        if (fault)
            return FAULT_CODE;
        else if (over)
            return OVER_CODE;
        else
            return digits;
    endfunction

    for (genvar i = 0; i < SCR_W / 4; i++) begin : g_add3
        bcd_add3 u_add3 (
            .d (scratch[4*i +: 4]),
            .q (scratch_adj[4*i +: 4])
        );
    end

    // A strobe on the FINISH edge is newer than anything pending, so it is loaded directly.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        load_bin   = tempBin;
        load_fault = sensorFault;
        case (state)
            ST_IDLE: begin
                if (tempValid) begin
                    load      = 1'b1;
                    state_nxt = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (cnt == LAST)
                    state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                if (tempValid) begin
                    load      = 1'b1;
                    state_nxt = ST_CONVERT;
                end else if (pend_vld) begin
                    load       = 1'b1;
                    load_bin   = pend_bin;
                    load_fault = pend_fault;
                    state_nxt  = ST_CONVERT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysCLK or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pend_vld    <= 1'b0;
            decimalTemp <= BLANK_CODE;
            display     <= 1'b0;
            updated     <= 1'b0;
        end else begin
            state   <= state_nxt;
            updated <= (state == ST_FINISH);
            if (load)
                cnt <= '0;
            else if (state == ST_CONVERT)
                cnt <= cnt + 1'b1;
            if (state == ST_FINISH)
                pend_vld <= 1'b0;
            else if (tempValid && state != ST_IDLE)
                pend_vld <= 1'b1;
            if (state == ST_FINISH) begin
                decimalTemp <= sel_code(fault_op, over_op, scratch[7:0]);
                display     <= 1'b1;
            end
        end
    end

    // Operand, scratch and pending data carry no reset; the control flags above qualify them.
    always_ff @(posedge sysCLK) begin
        if (load) begin
            op       <= load_bin;
            fault_op <= load_fault;
            over_op  <= (load_bin > MAX_V);
            scratch  <= '0;
        end else if (state == ST_CONVERT) begin
            {scratch, op} <= {scratch_adj[SCR_W-2:0], op, 1'b0};
        end
        if (tempValid && state != ST_IDLE) begin
            pend_bin   <= tempBin;
            pend_fault <= sensorFault;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
